mux_rr_arbiter: RTL

- Round-robin arbiter and sequencer for the 4x1 mux datapath: shares the single mux output among 4 requesters by driving its 2-bit select.
- Each requester presents data on its mux input lane and holds a request. The block grants one lane at a time and forwards that lane's data with a valid/ready handshake.
- A bounded burst length per grant prevents starvation.
- Sits between the 4 data producers and a single downstream consumer.

---
 rtl/mux_rr_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for a 4-lane mux. It grants one lane at a time, forwards that
// lane's data with a valid/ready handshake, and caps each grant at MAX_HOLD beats.
module mux_rr_arbiter #(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] din,
  input  logic            out_ready,
  output logic [1:0]      sel,
  output logic [3:0]      grant,
  output logic            out_valid,
  output logic [DW-1:0]   out_data
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;

  logic [1:0] pick;
  logic       found;
  logic [1:0] idx;
  logic       xfer;
  logic       last_beat;

  // Scan the lanes starting at ptr; the first requesting lane wins.
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    grant     = 4'b0000;
    out_valid = 1'b0;
    out_data  = '0;
    if (state_q == GRANT) begin
      grant     = 4'b0001 << sel_q;
      out_valid = req[sel_q];
      out_data  = din[sel_q*DW +: DW];
    end
  end

  assign sel       = sel_q;
  assign xfer      = out_valid & out_ready;
  assign last_beat = (cnt_q == 4'(MAX_HOLD - 1));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = pick;
          cnt_d   = 4'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A dropped request or the final allowed beat hands priority to the next lane.
        if (!req[sel_q] || (xfer && last_beat)) begin
          ptr_d   = sel_q + 2'd1;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (xfer) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
